// File: rtl/mbist_pkg.sv
// Shared types and default constants for the MBIST run sequencer.
package mbist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST,
      ST_RUN,
      ST_DIAG,
      ST_DONE
   } mbist_state_e;

   localparam int unsigned MBIST_RST_CYC_DEF     = 4;
   localparam int unsigned MBIST_TIMEOUT_CYC_DEF = 32'h00FF_FFFF;

endpackage

// File: rtl/mbist_diag_shreg.sv
// Diagnostic capture: shifts a serial fail stream MSB-first and publishes a
// DIAG_W-bit record with a one-cycle valid pulse once the last bit arrives.
// Only instantiated when MBIST_DIAG_CAPTURE_EN is defined.
module mbist_diag_shreg #(
   parameter int unsigned DIAG_W = 64
) (
   input  logic              bist_clk,
   input  logic              bist_rst_l,
   input  logic              clr,
   input  logic              shift_en,
   input  logic              din,
   output logic              last,
   output logic [DIAG_W-1:0] word,
   output logic              valid
);

   localparam int unsigned CW = (DIAG_W > 1) ? $clog2(DIAG_W) : 1;
   localparam int unsigned SW = DIAG_W - 1;

   logic [SW-1:0]     shift_q, shift_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DIAG_W-1:0] word_q, word_d;
   logic              valid_q, valid_d;

   assign last  = (cnt_q == CW'(DIAG_W - 1));
   assign word  = word_q;
   assign valid = valid_q;

   // Shift/count next-state; the final bit goes straight into the record.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      valid_d = 1'b0;
      if (clr) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (shift_en) begin
         shift_d = SW'({shift_q, din});
         if (last) begin
            cnt_d   = '0;
            word_d  = {shift_q, din};
            valid_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Capture state registers.
   always_ff @(posedge bist_clk or negedge bist_rst_l) begin
      if (!bist_rst_l) begin
         shift_q <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/mbist_run_seq.sv
// MBIST run sequencer: turns a start pulse into reset/run/done on the
// downstream controller, with pause, abort, watchdog and sticky status.
// Optional diagnostic capture is enabled by defining MBIST_DIAG_CAPTURE_EN.
module mbist_run_seq
   import mbist_pkg::*;
#(
   parameter int unsigned RST_CYC     = MBIST_RST_CYC_DEF,
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned TIMEOUT_CYC = MBIST_TIMEOUT_CYC_DEF,
   parameter int unsigned DIAG_W      = 64
) (
   input  logic              bist_clk,
   input  logic              bist_rst_l,
   input  logic              start,
   input  logic              abort,
   input  logic              pause,
   input  logic              debug_mode,
   output logic              ctl_bist_en,
   output logic              ctl_rst_l,
   output logic              ctl_hold_l,
   output logic              ctl_debugz,
   input  logic              ctl_done,
   input  logic              ctl_fail,
   input  logic              ctl_diag,
   output logic              busy,
   output logic              status_valid,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [CNT_W-1:0]  run_cycles,
   output logic [DIAG_W-1:0] diag_word,
   output logic              diag_valid
);

   localparam int unsigned      RST_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYC - 1);

   mbist_state_e     state_q, state_d;
   logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
   logic             sticky_q, sticky_d;
   logic             status_valid_q, status_valid_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic             timeout_q, timeout_d;
   logic             fail_at_done;

`ifdef MBIST_DIAG_CAPTURE_EN
   logic fail_prev_q, fail_prev_d;
   logic diag_taken_q, diag_taken_d;
   logic diag_shift, diag_clr, diag_last;

   mbist_diag_shreg #(.DIAG_W(DIAG_W)) u_diag (
      .bist_clk   (bist_clk),
      .bist_rst_l (bist_rst_l),
      .clr        (diag_clr),
      .shift_en   (diag_shift),
      .din        (ctl_diag),
      .last       (diag_last),
      .word       (diag_word),
      .valid      (diag_valid)
   );
`else
   logic unused_diag_in;
   assign unused_diag_in = debug_mode ^ ctl_diag;
   assign diag_word      = '0;
   assign diag_valid     = 1'b0;
`endif

   assign busy         = (state_q != ST_IDLE);
   assign status_valid = status_valid_q;
   assign pass         = pass_q;
   assign fail         = fail_q;
   assign timeout      = timeout_q;
   assign run_cycles   = run_cycles_q;
   assign fail_at_done = sticky_q | ctl_fail;

   // Next-state, controller drive and status updates; abort overrides last.
   always_comb begin
      state_d        = state_q;
      rst_cnt_d      = rst_cnt_q;
      run_cycles_d   = run_cycles_q;
      sticky_d       = sticky_q;
      status_valid_d = status_valid_q;
      pass_d         = pass_q;
      fail_d         = fail_q;
      timeout_d      = timeout_q;
      ctl_bist_en    = 1'b0;
      ctl_rst_l      = 1'b0;
      ctl_hold_l     = 1'b1;
      ctl_debugz     = 1'b1;
`ifdef MBIST_DIAG_CAPTURE_EN
      fail_prev_d    = ctl_fail;
      diag_taken_d   = diag_taken_q;
      diag_shift     = 1'b0;
      diag_clr       = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d        = ST_RST;
               rst_cnt_d      = '0;
               run_cycles_d   = '0;
               sticky_d       = 1'b0;
               status_valid_d = 1'b0;
               pass_d         = 1'b0;
               fail_d         = 1'b0;
               timeout_d      = 1'b0;
`ifdef MBIST_DIAG_CAPTURE_EN
               diag_taken_d   = 1'b0;
               diag_clr       = 1'b1;
`endif
            end
         end
         ST_RST: begin
            ctl_bist_en = 1'b1;
            if (rst_cnt_q == RST_LAST) state_d = ST_RUN;
            else                       rst_cnt_d = rst_cnt_q + RST_W'(1);
         end
         ST_RUN: begin
            ctl_bist_en = 1'b1;
            ctl_rst_l   = 1'b1;
            ctl_hold_l  = !pause;
`ifdef MBIST_DIAG_CAPTURE_EN
            ctl_debugz  = !debug_mode;
`endif
            sticky_d = sticky_q | ctl_fail;
            if (!pause && run_cycles_q != '1) run_cycles_d = run_cycles_q + CNT_W'(1);
            if (ctl_done) begin
               state_d        = ST_DONE;
               status_valid_d = 1'b1;
               fail_d         = fail_at_done;
               pass_d         = !fail_at_done;
               timeout_d      = 1'b0;
            end else if (!pause && run_cycles_q == WD_LAST) begin
               state_d        = ST_DONE;
               status_valid_d = 1'b1;
               fail_d         = 1'b1;
               pass_d         = 1'b0;
               timeout_d      = 1'b1;
            end
`ifdef MBIST_DIAG_CAPTURE_EN
            else if (debug_mode && ctl_fail && !fail_prev_q && !diag_taken_q) begin
               state_d      = ST_DIAG;
               diag_taken_d = 1'b1;
            end
`endif
         end
`ifdef MBIST_DIAG_CAPTURE_EN
         ST_DIAG: begin
            ctl_bist_en = 1'b1;
            ctl_rst_l   = 1'b1;
            ctl_hold_l  = 1'b0;
            ctl_debugz  = !debug_mode;
            diag_shift  = 1'b1;
            if (diag_last) state_d = ST_RUN;
         end
`endif
         ST_DONE: begin
            ctl_bist_en = 1'b1;
            ctl_rst_l   = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort && state_q != ST_IDLE) begin
         state_d        = ST_IDLE;
         status_valid_d = 1'b0;
         pass_d         = 1'b0;
         fail_d         = 1'b0;
         timeout_d      = 1'b0;
`ifdef MBIST_DIAG_CAPTURE_EN
         diag_clr       = 1'b1;
`endif
      end
   end

   // Sequencer state and status registers.
   always_ff @(posedge bist_clk or negedge bist_rst_l) begin
      if (!bist_rst_l) begin
         state_q        <= ST_IDLE;
         rst_cnt_q      <= '0;
         run_cycles_q   <= '0;
         sticky_q       <= 1'b0;
         status_valid_q <= 1'b0;
         pass_q         <= 1'b0;
         fail_q         <= 1'b0;
         timeout_q      <= 1'b0;
`ifdef MBIST_DIAG_CAPTURE_EN
         fail_prev_q    <= 1'b0;
         diag_taken_q   <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         rst_cnt_q      <= rst_cnt_d;
         run_cycles_q   <= run_cycles_d;
         sticky_q       <= sticky_d;
         status_valid_q <= status_valid_d;
         pass_q         <= pass_d;
         fail_q         <= fail_d;
         timeout_q      <= timeout_d;
`ifdef MBIST_DIAG_CAPTURE_EN
         fail_prev_q    <= fail_prev_d;
         diag_taken_q   <= diag_taken_d;
`endif
      end
   end

endmodule

// File: tb/tb_mbist_run_seq.sv
// Directed bench for mbist_run_seq. A second instance with a 50-cycle
// watchdog shares all inputs; MBIST_DIAG_CAPTURE_EN selects the diag checks.
module tb_mbist_run_seq;

   logic clk = 1'b0;
   logic rst_l = 1'b0;
   logic start = 1'b0, abort = 1'b0, pause = 1'b0, debug_mode = 1'b0;
   logic ctl_done = 1'b0, ctl_fail = 1'b0, ctl_diag = 1'b0;

   logic        bist_en, c_rst_l, hold_l, debugz, busy, sv, pass, fail, tmo, dvalid;
   logic [23:0] rcyc;
   logic [7:0]  dword;

   logic        w_bist_en, w_rst_l, w_hold_l, w_debugz, w_busy, w_sv, w_pass, w_fail, w_tmo, w_dvalid;
   logic [23:0] w_rcyc;
   logic [7:0]  w_dword;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mbist_run_seq #(.RST_CYC(4), .CNT_W(24), .DIAG_W(8)) u_dut (
      .bist_clk(clk), .bist_rst_l(rst_l), .start(start), .abort(abort), .pause(pause),
      .debug_mode(debug_mode), .ctl_bist_en(bist_en), .ctl_rst_l(c_rst_l), .ctl_hold_l(hold_l),
      .ctl_debugz(debugz), .ctl_done(ctl_done), .ctl_fail(ctl_fail), .ctl_diag(ctl_diag),
      .busy(busy), .status_valid(sv), .pass(pass), .fail(fail), .timeout(tmo),
      .run_cycles(rcyc), .diag_word(dword), .diag_valid(dvalid)
   );

   mbist_run_seq #(.RST_CYC(4), .CNT_W(24), .TIMEOUT_CYC(50), .DIAG_W(8)) u_wd (
      .bist_clk(clk), .bist_rst_l(rst_l), .start(start), .abort(abort), .pause(pause),
      .debug_mode(debug_mode), .ctl_bist_en(w_bist_en), .ctl_rst_l(w_rst_l), .ctl_hold_l(w_hold_l),
      .ctl_debugz(w_debugz), .ctl_done(ctl_done), .ctl_fail(ctl_fail), .ctl_diag(ctl_diag),
      .busy(w_busy), .status_valid(w_sv), .pass(w_pass), .fail(w_fail), .timeout(w_tmo),
      .run_cycles(w_rcyc), .diag_word(w_dword), .diag_valid(w_dvalid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves both instances in RUN cycle 0.
   task automatic start_session();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
   endtask

   initial begin
      int rst_low;
      logic [7:0] bits;

      // Reset values
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_bist_en", bist_en, 0);
      check("rst_ctl_rst_l", c_rst_l, 0);
      check("rst_hold_l", hold_l, 1);
      check("rst_debugz", debugz, 1);
      check("rst_status", {sv, pass, fail, tmo}, 4'b0000);
      check("rst_run_cycles", rcyc, 0);
      check("rst_diag", {dvalid, dword}, 0);
      rst_l = 1'b1;
      step();

      // Pass: done in RUN cycle 99
      start = 1'b1;
      step();
      start = 1'b0;
      check("p_busy", busy, 1);
      check("p_bist_en_rst", bist_en, 1);
      rst_low = 0;
      for (int n = 0; n < 20; n++) begin
         if (c_rst_l === 1'b0 && busy === 1'b1) rst_low++;
         else break;
         step();
      end
      check("p_rst_low_cycles", rst_low, 4);
      check("p_run0_cycles", rcyc, 0);
      check("p_run0_hold", hold_l, 1);
      repeat (99) step();
      ctl_done = 1'b1;
      step();
      ctl_done = 1'b0;
      check("p_done_status", {sv, pass, fail, tmo}, 4'b1100);
      check("p_done_run_cycles", rcyc, 100);
      check("p_done_bist_en", bist_en, 1);
      step();
      check("p_idle_busy", busy, 0);
      check("p_idle_bist_en", bist_en, 0);
      check("p_idle_status_held", {sv, pass, fail, tmo}, 4'b1100);

      // Sticky fail: pulse in RUN cycle 20, done in 99 with ctl_fail low
      start_session();
      check("f_status_cleared", {sv, pass, fail, tmo}, 4'b0000);
      repeat (20) step();
      ctl_fail = 1'b1;
      step();
      ctl_fail = 1'b0;
      repeat (78) step();
      ctl_done = 1'b1;
      step();
      ctl_done = 1'b0;
      check("f_done_status", {sv, pass, fail, tmo}, 4'b1010);
      check("f_run_cycles", rcyc, 100);
      step();

      // Watchdog at 50 run cycles
      start_session();
      repeat (49) step();
      check("t_pre_busy", w_busy, 1);
      check("t_pre_cycles", w_rcyc, 49);
      step();
      check("t_done_status", {w_sv, w_pass, w_fail, w_tmo}, 4'b1011);
      check("t_done_cycles", w_rcyc, 50);
      step();
      check("t_idle_busy", w_busy, 0);
      check("t_idle_held", {w_sv, w_pass, w_fail, w_tmo}, 4'b1011);
      abort = 1'b1;
      step();
      abort = 1'b0;

      // Done coinciding with watchdog: done wins
      start_session();
      repeat (49) step();
      ctl_done = 1'b1;
      step();
      ctl_done = 1'b0;
      check("te_status", {w_sv, w_pass, w_fail, w_tmo}, 4'b1100);
      check("te_cycles", w_rcyc, 50);
      check("te_main_cycles", rcyc, 50);
      step();

      // Pause during RUN cycles 10-19
      start_session();
      repeat (10) step();
      pause = 1'b1;
      #1;
      check("pz_hold_low", hold_l, 0);
      check("pz_bist_en", bist_en, 1);
      repeat (10) step();
      check("pz_frozen", rcyc, 10);
      check("pz_wd_frozen", w_rcyc, 10);
      pause = 1'b0;
      #1;
      check("pz_hold_high", hold_l, 1);
      repeat (79) step();
      ctl_done = 1'b1;
      step();
      ctl_done = 1'b0;
      check("pz_done_cycles", rcyc, 90);
      check("pz_done_status", {sv, pass, fail, tmo}, 4'b1100);
      step();

      // Abort beats start and done
      start_session();
      repeat (5) step();
      abort = 1'b1;
      start = 1'b1;
      ctl_done = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      ctl_done = 1'b0;
      check("ab_busy", busy, 0);
      check("ab_status", {sv, pass, fail, tmo}, 4'b0000);
      check("ab_bist_en", bist_en, 0);
      check("ab_ctl_rst_l", c_rst_l, 0);
      step();
      check("ab_stays_idle", busy, 0);

      // Start while busy is ignored
      start_session();
      repeat (3) step();
      start = 1'b1;
      step();
      start = 1'b0;
      check("sb_busy", busy, 1);
      check("sb_no_restart", rcyc, 4);
      check("sb_ctl_rst_l", c_rst_l, 1);
      repeat (5) step();
      ctl_done = 1'b1;
      step();
      ctl_done = 1'b0;
      check("sb_done_cycles", rcyc, 10);
      step();

      // Diagnostic capture
      debug_mode = 1'b1;
      start_session();
`ifdef MBIST_DIAG_CAPTURE_EN
      check("dg_debugz", debugz, 0);
      repeat (5) step();
      ctl_fail = 1'b1;
      step();
      ctl_fail = 1'b0;
      check("dg_hold_low", hold_l, 0);
      check("dg_cycles", rcyc, 6);
      bits = 8'hB2;
      for (int i = 0; i < 8; i++) begin
         ctl_diag = bits[7-i];
         step();
      end
      ctl_diag = 1'b0;
      check("dg_valid", dvalid, 1);
      check("dg_word", dword, 8'hB2);
      check("dg_resume_hold", hold_l, 1);
      check("dg_frozen_cycles", rcyc, 6);
      step();
      check("dg_valid_pulse", dvalid, 0);
      ctl_fail = 1'b1;
      step();
      ctl_fail = 1'b0;
      check("dg_one_record", hold_l, 1);
      ctl_done = 1'b1;
      step();
      ctl_done = 1'b0;
      check("dg_done_status", {sv, pass, fail, tmo}, 4'b1010);
`else
      check("nd_debugz", debugz, 1);
      repeat (5) step();
      ctl_fail = 1'b1;
      step();
      ctl_fail = 1'b0;
      check("nd_hold", hold_l, 1);
      check("nd_cycles", rcyc, 6);
      bits = 8'hB2;
      for (int i = 0; i < 8; i++) begin
         ctl_diag = bits[7-i];
         step();
      end
      ctl_diag = 1'b0;
      check("nd_diag", {dvalid, dword}, 0);
      ctl_done = 1'b1;
      step();
      ctl_done = 1'b0;
      check("nd_done_status", {sv, pass, fail, tmo}, 4'b1010);
`endif
      debug_mode = 1'b0;
      step();

      // Asynchronous reset mid-session
      start_session();
      repeat (3) step();
      #2;
      rst_l = 1'b0;
      #1;
      check("ar_busy", busy, 0);
      check("ar_ctl_rst_l", c_rst_l, 0);
      check("ar_bist_en", bist_en, 0);
      check("ar_status", {sv, pass, fail, tmo}, 4'b0000);
      check("ar_cycles", rcyc, 0);
      step();
      rst_l = 1'b1;
      step();
      check("ar_after_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
